cheri_lsu: RTL and testbench

Parametrised, capability-checked load/store unit that replaces the single-cycle combinational memory path of the core. It accepts one load or store request at a time from the execute stage and checks it against the supplied capability: tag, permission, size-aware bounds and alignment. Legal accesses are issued over a req/ack data-memory handshake with a timeout. Each request ends in exactly one response pulse carrying either load data or a registered fault cause.

---
 rtl/cheri_lsu.sv | 133 +++++++++++++
 tb/tb_cheri_lsu.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cheri_lsu.sv
// cheri_lsu: capability-checked load/store unit with a req/ack memory port and timeout.
module cheri_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              cap_tag,
  input  logic [XLEN-1:0]   cap_base,
  input  logic [XLEN-1:0]   cap_length,
  input  logic              cap_perm_load,
  input  logic              cap_perm_store,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic [2:0]        rsp_cause
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CHECK, MEM, RESP} state_t;
  state_t            state_q;
  logic              store_q, uns_q, tag_q, pl_q, ps_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   addr_q, wdata_q, base_q, len_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        n;
  logic [LW-1:0]     lane;
  logic [XLEN:0]     end_a, lim;
  logic              in_b, mis;
  logic [2:0]        cause_d;
  logic [15:0]       ones;
  logic [NB-1:0]     strb_d;
  logic [XLEN-1:0]   wrep_d, sh, msk, ld_d;
  int                sbi;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  // bounds sums carry one extra bit so a capability reaching the top of memory cannot wrap
  always_comb begin
    n       = 4'd1 << size_q;
    lane    = addr_q[LW-1:0];
    end_a   = {1'b0, addr_q} + (XLEN+1)'(n);
    lim     = {1'b0, base_q} + {1'b0, len_q};
    in_b    = (addr_q >= base_q) && (end_a <= lim);
    mis     = ((addr_q & XLEN'(n - 4'd1)) != '0) || (XLEN == 32 && size_q == 2'b11);
    cause_d = !tag_q ? 3'd1 : (store_q && !ps_q) ? 3'd3 : (!store_q && !pl_q) ? 3'd2 :
              !in_b ? 3'd4 : mis ? 3'd5 : 3'd0;
    ones    = (16'd1 << n) - 16'd1;
    strb_d  = NB'(ones) << lane;
    wrep_d  = '0;
    for (int i = 0; i < NB; i++) wrep_d[i*8 +: 8] = wdata_q[((i & (int'(n) - 1)) & (NB - 1))*8 +: 8];
    sh      = mem_rdata >> {lane, 3'b000};
    msk     = ~({XLEN{1'b1}} << {n, 3'b000});
    sbi     = ((8 << size_q) - 1) & (XLEN - 1);
    ld_d    = (sh & msk) | ((!uns_q && sh[sbi]) ? ~msk : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      {store_q, uns_q, tag_q, pl_q, ps_q} <= '0;
      size_q    <= '0;
      {addr_q, wdata_q, base_q, len_q} <= '0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      rsp_cause <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= CHECK;
          {store_q, uns_q, tag_q, pl_q, ps_q} <= {req_store, req_unsigned, cap_tag, cap_perm_load, cap_perm_store};
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          base_q  <= cap_base;
          len_q   <= cap_length;
        end
        CHECK: if (cause_d != 3'd0) begin
          state_q   <= RESP;
          rsp_fault <= 1'b1;
          rsp_cause <= cause_d;
        end else begin
          state_q   <= MEM;
          cnt_q     <= '0;
          mem_req   <= 1'b1;
          mem_we    <= store_q;
          mem_addr  <= addr_q & ~XLEN'(NB - 1);
          mem_wdata <= store_q ? wrep_d : '0;
          mem_wstrb <= store_q ? strb_d : '0;
        end
        MEM: if (cnt_q == CW'(TIMEOUT) || mem_ack) begin
          state_q   <= RESP;
          rsp_fault <= cnt_q == CW'(TIMEOUT);
          rsp_cause <= cnt_q == CW'(TIMEOUT) ? 3'd6 : 3'd0;
          rsp_rdata <= (cnt_q == CW'(TIMEOUT) || store_q) ? '0 : ld_d;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(TIMEOUT)) mem_req <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          rsp_rdata <= '0;
          rsp_fault <= 1'b0;
          rsp_cause <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cheri_lsu.sv
// tb_cheri_lsu: randomized and directed checks of cheri_lsu against a behavioural access model.
module tb_cheri_lsu;
  localparam int TO = 15;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_store = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, cap_base = 0, cap_length = 0;
  logic        cap_tag = 0, cap_perm_load = 0, cap_perm_store = 0;
  logic        mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_cause;
  int          checks = 0, errors = 0;

  cheri_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .cap_tag(cap_tag), .cap_base(cap_base),
    .cap_length(cap_length), .cap_perm_load(cap_perm_load), .cap_perm_store(cap_perm_store),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the unit idle; returns at a falling edge with it idle again.
  task automatic txn(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                     input logic [31:0] wd, input logic tg, input logic [31:0] b, input logic [31:0] l,
                     input logic pl, input logic ps, input int ack_k, input logic [31:0] rd);
    int n, rc, mc, erc, emc;
    logic [2:0] ec;
    logic tmo, seen, s_we;
    logic [31:0] s_addr, s_wdata, ew, erd;
    logic [3:0] s_strb, es;
    logic [63:0] v, m;
    n = 1 << sz;
    if (!tg) ec = 1;
    else if (st && !ps) ec = 3;
    else if (!st && !pl) ec = 2;
    else if (!(64'(a) >= 64'(b) && 64'(a) + 64'(n) <= 64'(b) + 64'(l))) ec = 4;
    else if ((a % n) != 0 || sz == 2'd3) ec = 5;
    else ec = 0;
    tmo = ec == 0 && !(ack_k >= 0 && ack_k < TO);
    erc = ec != 0 ? 2 : tmo ? 3 + TO : 3 + ack_k;
    emc = ec != 0 ? 0 : tmo ? TO : ack_k + 1;
    v = 64'(rd) >> (8 * (a % 4));
    m = (n == 8) ? '1 : (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (!un && v[8*n-1]) v = v | ~m;
    erd = (ec != 0 || tmo || st) ? 32'd0 : v[31:0];
    es = st ? 4'(((1 << n) - 1) << (a % 4)) : 4'd0;
    for (int i = 0; i < 4; i++) ew[i*8 +: 8] = wd[(i % n)*8 +: 8];
    chk("ready_before", req_ready, 1);
    {req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata} = {1'b1, st, sz, un, a, wd};
    {cap_tag, cap_base, cap_length, cap_perm_load, cap_perm_store} = {tg, b, l, pl, ps};
    mem_rdata = rd;
    rc = -1; mc = 0; seen = 0;
    s_we = 0; s_addr = 0; s_wdata = 0; s_strb = 0;
    for (int c = 1; c <= TO + 8 && rc < 0; c++) begin
      @(negedge clk);
      req_valid = 0;
      if (mem_req) begin
        if (!seen) {s_we, s_addr, s_wdata, s_strb} = {mem_we, mem_addr, mem_wdata, mem_wstrb};
        seen = 1;
        mc++;
      end
      if (rsp_valid) begin
        rc = c;
        chk("rsp_fault", rsp_fault, ec != 0 || tmo);
        chk("rsp_cause", rsp_cause, ec != 0 ? ec : tmo ? 3'd6 : 3'd0);
        chk("rsp_rdata", rsp_rdata, erd);
      end
      mem_ack = ack_k >= 0 && c == 2 + ack_k;
    end
    mem_ack = 0;
    chk("rsp_cycle", 64'(rc), 64'(erc));
    chk("mem_req_cycles", 64'(mc), 64'(emc));
    if (ec == 0) begin
      chk("mem_we", s_we, st);
      chk("mem_addr", s_addr, a & ~32'd3);
      chk("mem_wstrb", s_strb, es);
      if (st) chk("mem_wdata", s_wdata, ew);
    end
    @(negedge clk);
    chk("rsp_pulse", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int rsp_seen;
    logic [31:0] b, l, a;
    logic [1:0] sz;
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_outs", {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid, rsp_rdata, rsp_fault, rsp_cause},
        '0);
    rst_n = 1;
    @(negedge clk);
    txn(0, 2'd0, 0, 32'h1010, 0, 1, 32'h1000, 32'h100, 1, 1, 2, 32'h8000_00F0);
    txn(1, 2'd1, 0, 32'h1012, 32'hABCD, 1, 32'h1000, 32'h100, 1, 1, 0, 0);
    txn(0, 2'd2, 0, 32'h10FC, 0, 1, 32'h1000, 32'h100, 1, 1, 1, 32'h1234_5678);
    txn(0, 2'd2, 0, 32'h10FD, 0, 1, 32'h1000, 32'h100, 1, 1, 0, 0);
    txn(0, 2'd2, 0, 32'h10F9, 0, 1, 32'h1000, 32'h100, 1, 1, 0, 0);
    txn(0, 2'd2, 0, 32'h1100, 0, 1, 32'h1000, 32'h100, 1, 1, 0, 0);
    txn(0, 2'd2, 0, 32'h2000, 0, 0, 32'h1000, 32'h100, 1, 1, 0, 0);
    txn(1, 2'd2, 0, 32'h1010, 32'h55, 1, 32'h1000, 32'h100, 1, 0, 0, 0);
    txn(0, 2'd2, 0, 32'h1010, 0, 1, 32'h1000, 32'h100, 0, 1, 0, 0);
    txn(0, 2'd2, 1, 32'h1010, 0, 1, 32'h1000, 32'h100, 1, 1, -1, 0);
    txn(0, 2'd2, 1, 32'h1010, 0, 1, 32'h1000, 32'h100, 1, 1, TO - 1, 32'hCAFE_F00D);
    txn(0, 2'd0, 1, 32'hFFFF_FFFE, 0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0, 32'h7700_0000);
    txn(0, 2'd0, 1, 32'hFFFF_FFFF, 0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0, 0);
    txn(0, 2'd3, 0, 32'h1010, 0, 1, 32'h1000, 32'h100, 1, 1, 0, 0);
    // abort a live access with reset, then confirm the unit recovers
    {req_valid, req_store, req_size, req_addr, cap_tag, cap_base, cap_length, cap_perm_load} =
      {1'b1, 1'b0, 2'd2, 32'h1010, 1'b1, 32'h1000, 32'h100, 1'b1};
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("rst_pre_memreq", mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async", {mem_req, req_ready, rsp_valid}, 3'b010);
    @(negedge clk);
    rst_n = 1;
    rsp_seen = 0;
    repeat (4) begin
      @(negedge clk);
      rsp_seen += int'(rsp_valid);
    end
    chk("rst_no_rsp", 64'(rsp_seen), 0);
    txn(0, 2'd1, 0, 32'h1012, 0, 1, 32'h1000, 32'h100, 1, 1, 1, 32'h8001_0000);
    for (int t = 0; t < 200; t++) begin
      b = $urandom_range(0, 32'h0001_0000);
      l = $urandom_range(0, 64);
      sz = 2'($urandom_range(0, 3));
      a = b + $urandom_range(0, l + 8) - 32'd4;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      txn($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom,
          $urandom_range(0, 15) != 0, b, l, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, TO + 1)), $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
